// File: rtl/fp_multiplier_if.sv
// Operand/result handshake bundle between the multiplier and its neighbours.
// The master drives operands and their rdy flags; the slave returns the product and done.
interface fp_multiplier_if;
  logic [31:0] x_data;
  logic [31:0] y_data;
  logic        x_rdy;
  logic        y_rdy;
  logic [31:0] z_data;
  logic        done;

  modport master (
    output x_data, y_data, x_rdy, y_rdy,
    input  z_data, done
  );

  modport slave (
    input  x_data, y_data, x_rdy, y_rdy,
    output z_data, done
  );
endinterface

// File: rtl/fp_multiplier.sv
// Multi-cycle IEEE-754 binary32 multiplier with round-to-nearest-even and
// denormal support; its z_data/done feed the float adder's operand handshake.
module fp_multiplier (
  input  logic            clk,
  input  logic            rst,
  fp_multiplier_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, NORM_IN, MULT, PRODUCT, DENORM, ROUND, PACK, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        xRaw_q, xRaw_d;
  logic [31:0]        yRaw_q, yRaw_d;
  logic [23:0]        xM_q, xM_d;
  logic [23:0]        yM_q, yM_d;
  logic signed [9:0]  xE_q, xE_d;
  logic signed [9:0]  yE_q, yE_d;
  logic               zS_q, zS_d;
  logic signed [9:0]  zE_q, zE_d;
  logic [23:0]        zM_q, zM_d;
  logic [47:0]        prod_q, prod_d;
  logic               guard_q, guard_d;
  logic               round_q, round_d;
  logic               sticky_q, sticky_d;
  logic               zReady_q, zReady_d;
  logic [31:0]        zData_q, zData_d;
  logic               done_q, done_d;

  logic xNan, yNan, xInf, yInf, xZero, yZero;
  logic [7:0] packExp;

  assign xNan  = (xRaw_q[30:23] == 8'hFF) && (|xRaw_q[22:0]);
  assign yNan  = (yRaw_q[30:23] == 8'hFF) && (|yRaw_q[22:0]);
  assign xInf  = (xRaw_q[30:23] == 8'hFF) && !(|xRaw_q[22:0]);
  assign yInf  = (yRaw_q[30:23] == 8'hFF) && !(|yRaw_q[22:0]);
  assign xZero = (xRaw_q[30:23] == 8'h00) && !(|xRaw_q[22:0]);
  assign yZero = (yRaw_q[30:23] == 8'h00) && !(|yRaw_q[22:0]);

  // Only the low byte matters: after rounding z_e lies in -126..127 here.
  assign packExp = zE_q[7:0] + 8'd127;

  assign bus.z_data = zData_q;
  assign bus.done   = done_q;

  always_comb begin
    state_d  = state_q;
    xRaw_d   = xRaw_q;
    yRaw_d   = yRaw_q;
    xM_d     = xM_q;
    yM_d     = yM_q;
    xE_d     = xE_q;
    yE_d     = yE_q;
    zS_d     = zS_q;
    zE_d     = zE_q;
    zM_d     = zM_q;
    prod_d   = prod_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    zReady_d = zReady_q;
    zData_d  = zData_q;
    done_d   = done_q;

    case (state_q)
      IDLE: begin
        if (bus.x_rdy && bus.y_rdy) begin
          xRaw_d  = bus.x_data;
          yRaw_d  = bus.y_data;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        zS_d     = xRaw_q[31] ^ yRaw_q[31];
        zReady_d = 1'b0;
        if (xRaw_q[30:23] == 8'h00) begin
          xE_d = -10'sd126;
          xM_d = {1'b0, xRaw_q[22:0]};
        end else begin
          xE_d = $signed({2'b00, xRaw_q[30:23]}) - 10'sd127;
          xM_d = {1'b1, xRaw_q[22:0]};
        end
        if (yRaw_q[30:23] == 8'h00) begin
          yE_d = -10'sd126;
          yM_d = {1'b0, yRaw_q[22:0]};
        end else begin
          yE_d = $signed({2'b00, yRaw_q[30:23]}) - 10'sd127;
          yM_d = {1'b1, yRaw_q[22:0]};
        end
        state_d = SPECIAL;
      end

      // Special results are written here and published through PACK one edge later.
      SPECIAL: begin
        state_d  = PACK;
        zReady_d = 1'b1;
        if (xNan || yNan) begin
          zData_d = 32'h7FC0_0000;
        end else if ((xInf && yZero) || (xZero && yInf)) begin
          zData_d = 32'h7FC0_0000;
        end else if (xInf || yInf) begin
          zData_d = {zS_q, 8'hFF, 23'd0};
        end else if (xZero || yZero) begin
          zData_d = {zS_q, 31'd0};
        end else begin
          zReady_d = 1'b0;
          state_d  = NORM_IN;
        end
      end

      NORM_IN: begin
        if (!xM_q[23]) begin
          xM_d = xM_q << 1;
          xE_d = xE_q - 10'sd1;
        end else if (!yM_q[23]) begin
          yM_d = yM_q << 1;
          yE_d = yE_q - 10'sd1;
        end else begin
          state_d = MULT;
        end
      end

      MULT: begin
        prod_d  = {24'd0, xM_q} * {24'd0, yM_q};
        zE_d    = xE_q + yE_q;
        state_d = PRODUCT;
      end

      PRODUCT: begin
        if (prod_q[47]) begin
          zM_d     = prod_q[47:24];
          guard_d  = prod_q[23];
          round_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
          zE_d     = zE_q + 10'sd1;
        end else begin
          zM_d     = prod_q[46:23];
          guard_d  = prod_q[22];
          round_d  = prod_q[21];
          sticky_d = |prod_q[20:0];
        end
        state_d = DENORM;
      end

      // Shift into the denormal range; a mantissa shifted out entirely becomes a signed zero.
      DENORM: begin
        if (zM_q == 24'd0) begin
          zData_d  = {zS_q, 31'd0};
          zReady_d = 1'b1;
          state_d  = PACK;
        end else if (zE_q < -10'sd126) begin
          zM_d     = zM_q >> 1;
          zE_d     = zE_q + 10'sd1;
          guard_d  = zM_q[0];
          round_d  = guard_q;
          sticky_d = sticky_q | round_q;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        if (guard_q && (round_q || sticky_q || zM_q[0])) begin
          if (zM_q == 24'hFF_FFFF) begin
            zM_d = 24'h80_0000;
            zE_d = zE_q + 10'sd1;
          end else begin
            zM_d = zM_q + 24'd1;
          end
        end
        state_d = PACK;
      end

      PACK: begin
        done_d  = 1'b1;
        state_d = DONE;
        if (!zReady_q) begin
          if (zE_q > 10'sd127) begin
            zData_d = {zS_q, 8'hFF, 23'd0};
          end else if ((zE_q == -10'sd126) && !zM_q[23]) begin
            zData_d = {zS_q, 8'h00, zM_q[22:0]};
          end else begin
            zData_d = {zS_q, packExp, zM_q[22:0]};
          end
        end
      end

      DONE: begin
        if (!(bus.x_rdy && bus.y_rdy)) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      xRaw_q   <= '0;
      yRaw_q   <= '0;
      xM_q     <= '0;
      yM_q     <= '0;
      xE_q     <= '0;
      yE_q     <= '0;
      zS_q     <= 1'b0;
      zE_q     <= '0;
      zM_q     <= '0;
      prod_q   <= '0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      zReady_q <= 1'b0;
      zData_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xRaw_q   <= xRaw_d;
      yRaw_q   <= yRaw_d;
      xM_q     <= xM_d;
      yM_q     <= yM_d;
      xE_q     <= xE_d;
      yE_q     <= yE_d;
      zS_q     <= zS_d;
      zE_q     <= zE_d;
      zM_q     <= zM_d;
      prod_q   <= prod_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      zReady_q <= zReady_d;
      zData_q  <= zData_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// Scoreboard bench for fp_multiplier: expected products and latencies are queued
// when operands are driven and compared when done rises.
module tb_fp_multiplier;

  logic clk = 1'b0;
  logic rst;

  fp_multiplier_if bus ();

  fp_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [31:0] expQ[$];
  int          latQ[$];

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present operands, queue the expected product and latency, then scramble the inputs after capture.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] expZ, input int expLat);
    @(negedge clk);
    bus.x_data = x;
    bus.y_data = y;
    bus.x_rdy  = 1'b1;
    bus.y_rdy  = 1'b1;
    expQ.push_back(expZ);
    latQ.push_back(expLat);
    @(posedge clk);
    #1;
    bus.x_data = $urandom;
    bus.y_data = $urandom;
  endtask

  // Count edges after capture until done, then pop and compare.
  task automatic waitResult(input string tag);
    int n = 0;
    logic [31:0] e;
    int l;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 400);
    e = expQ.pop_front();
    l = latQ.pop_front();
    if (!bus.done) begin
      checkOutput({tag, " timeout"}, {31'd0, bus.done}, 32'd1);
    end else begin
      checkOutput(tag, bus.z_data, e);
      if (l > 0) checkOutput({tag, " latency"}, n, l);
    end
  endtask

  task automatic releaseBus(input string tag);
    @(negedge clk);
    bus.x_rdy = 1'b0;
    bus.y_rdy = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, " release"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic runCase(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] expZ, input int expLat);
    applyStimulus(x, y, expZ, expLat);
    waitResult(tag);
    releaseBus(tag);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    bus.x_data = '0;
    bus.y_data = '0;
    bus.x_rdy  = 1'b0;
    bus.y_rdy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset z", bus.z_data, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    runCase("mul 1.5*2",    32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 8);
    runCase("mul -2.5*4",   32'hC020_0000, 32'h4080_0000, 32'hC120_0000, 8);
    runCase("mul 3*3",      32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 8);
    runCase("rnd sticky",   32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 8);
    runCase("rnd tie",      32'h3F80_0001, 32'h3F7F_FFFF, 32'h3F80_0000, 8);
    runCase("rnd up",       32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002, 8);
    runCase("inf*0",        32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3);
    runCase("-inf*2",       32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3);
    runCase("-0*1",         32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3);
    runCase("nan*1",        32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3);
    runCase("overflow",     32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 8);
    runCase("denorm out",   32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 9);
    runCase("underflow",    32'h0000_0001, 32'h3F00_0000, 32'h0000_0000, 0);
    runCase("neg underflow",32'h8000_0001, 32'h3F00_0000, 32'h8000_0000, 0);
    runCase("denorm in",    32'h0040_0000, 32'h4000_0000, 32'h0080_0000, 9);

    // Holding both rdy high after done must keep the result and never recapture.
    applyStimulus(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 8);
    waitResult("hs first");
    @(negedge clk);
    bus.x_data = 32'h4080_0000;
    bus.y_data = 32'h4080_0000;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("hs hold done", {31'd0, bus.done}, 32'd1);
    checkOutput("hs hold z", bus.z_data, 32'h4040_0000);
    @(negedge clk);
    bus.x_rdy = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("hs drop done", {31'd0, bus.done}, 32'd0);
    checkOutput("hs drop z", bus.z_data, 32'h4040_0000);
    @(negedge clk);
    bus.y_rdy = 1'b0;
    @(posedge clk);
    runCase("hs new", 32'hC020_0000, 32'h4080_0000, 32'hC120_0000, 8);

    // Abort an operation with reset while it sits in MULT.
    @(negedge clk);
    bus.x_data = 32'h4040_0000;
    bus.y_data = 32'h4040_0000;
    bus.x_rdy  = 1'b1;
    bus.y_rdy  = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    bus.x_rdy = 1'b0;
    bus.y_rdy = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort done", {31'd0, bus.done}, 32'd0);
    checkOutput("abort z", bus.z_data, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort idle done", {31'd0, bus.done}, 32'd0);
    runCase("post reset", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
